seq_mult: RTL and testbench



---
 rtl/seq_mult_pkg.sv | 23 ++
 rtl/seq_mult_dp.sv | 63 ++++++
 rtl/seq_mult.sv | 83 ++++++++
 tb/tb_seq_mult.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state encoding and sizing helper for the sequential
// shift-add multiplier (seq_mult / seq_mult_dp).
package seq_mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ceiling log2; clog2(1) = 0. Used to size the iteration counter.
  function automatic int clog2(input int val);
    int res;
    int rem;
    res = 0;
    rem = val - 1;
    while (rem > 0) begin
      res++;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// seq_mult_dp: datapath of the shift-add multiplier. Holds the multiplicand
// and multiplier shift registers, the accumulator and the product register.
// Optional macro SEQ_MULT_SIGNED_EN: two's complement operands; the final
// (sign-bit) iteration subtracts instead of adding.
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int A_W = 8,
  parameter int B_W = 4,
  parameter int P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           finish,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] product
);

  logic [P_W-1:0] mcand;
  logic [B_W-1:0] mplier;
  logic [P_W-1:0] acc;
  logic [P_W-1:0] addend;
  logic [P_W-1:0] acc_next;
  logic [P_W-1:0] a_ext;

  // Operand extension and next accumulator value for the current bit
  always_comb begin
    addend = mplier[0] ? mcand : '0;
`ifdef SEQ_MULT_SIGNED_EN
    a_ext    = {{B_W{a[A_W-1]}}, a};
    // The multiplier's top bit carries negative weight, so it subtracts.
    acc_next = finish ? (acc - addend) : (acc + addend);
`else
    a_ext    = {{B_W{1'b0}}, a};
    acc_next = acc + addend;
`endif
  end

  // Capture operands on load, retire one multiplier bit per step
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      product <= '0;
    end else if (load) begin
      mcand  <= a_ext;
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (finish) begin
        product <= acc_next;
      end
    end
  end

endmodule

// File: rtl/seq_mult.sv
// seq_mult: parametrised sequential shift-add multiplier, one multiplier bit
// per clock, B_W cycles from accepted start to done.
// Optional macro SEQ_MULT_SIGNED_EN: signed (two's complement) operands.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int A_W = 8,
  parameter int B_W = 4,
  localparam int P_W = A_W + B_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] product
);

  localparam int CNT_W = clog2(B_W) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             load;
  logic             step;
  logic             finish;

  // Datapath strobes decoded from the current state and counter
  always_comb begin
    last   = (cnt == CNT_W'(B_W - 1));
    load   = (state == IDLE) && start;
    step   = (state == RUN);
    finish = step && last;
  end

  // Sequencing FSM with registered busy/done
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  seq_mult_dp #(
    .A_W(A_W),
    .B_W(B_W),
    .P_W(P_W)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .finish (finish),
    .a      (a),
    .b      (b),
    .product(product)
  );

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed and random checks of seq_mult at 8x4 and 16x8.
module tb_seq_mult;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [3:0]  b;
  logic        busy;
  logic        done;
  logic [11:0] product;

  logic        start2;
  logic [15:0] a2;
  logic [7:0]  b2;
  logic        busy2;
  logic        done2;
  logic [23:0] product2;

  int n_chk;
  int n_pass;

  seq_mult #(.A_W(8), .B_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  seq_mult #(.A_W(16), .B_W(8)) u_dut16 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .product(product2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one 8x4 operation, verify latency, busy and product.
  task automatic run8(input string tag, input logic [7:0] av, input logic [3:0] bv,
                      input logic [11:0] exp);
    int cyc;
    bit busy_bad;
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 4'($urandom);
    chk({tag, "_busy_set"}, busy, 1);
    cyc = 0; busy_bad = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (!done && !busy) busy_bad = 1;
    end
    chk({tag, "_latency"}, cyc, 4);
    chk({tag, "_busy_hold"}, busy_bad, 0);
    chk({tag, "_product"}, product, exp);
    chk({tag, "_busy_clr"}, busy, 0);
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [23:0] exp24;
    logic signed [23:0] sa;
    logic signed [23:0] sb;

    n_chk = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);

    // Basic, then back-to-back from the done cycle
    run8("basic", 8'h1F, 4'h2, 12'h03E);
    run8("b2b", 8'h1D, 4'h3, 12'h057);
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0);
    chk("product_hold", product, 12'h057);

    // Extremes
`ifdef SEQ_MULT_SIGNED_EN
    run8("ext_ff_f", 8'hFF, 4'hF, 12'h001);
    run8("signed_5_m2", 8'h05, 4'hE, 12'hFF6);
`else
    run8("ext_ff_f", 8'hFF, 4'hF, 12'hEF1);
    run8("uns_5_14", 8'h05, 4'hE, 12'h046);
`endif
    run8("ext_00_f", 8'h00, 4'hF, 12'h000);

    // Busy protection: second start two cycles in must be ignored
    start = 1'b1; a = 8'h10; b = 4'h5;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      if (cyc == 1) begin start = 1'b1; a = 8'h01; b = 4'h1; end
      else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("busyprot_latency", cyc, 4);
    chk("busyprot_product", product, 12'h050);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    chk("busyprot_no_extra_op", seen, 0);

    // Reset mid-operation
    start = 1'b1; a = 8'h10; b = 4'h5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_product", product, 0);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("midrst_no_done", seen, 0);

    // Random 16x8 against a reference product
    for (int i = 0; i < 1000; i++) begin
      start2 = 1'b1;
      if (i == 0) begin a2 = 16'hFFFF; b2 = 8'hFF; end
      else if (i == 1) begin a2 = 16'h8000; b2 = 8'h80; end
      else begin a2 = 16'($urandom); b2 = 8'($urandom); end
`ifdef SEQ_MULT_SIGNED_EN
      sa = {{8{a2[15]}}, a2};
      sb = {{16{b2[7]}}, b2};
      exp24 = sa * sb;
`else
      sa = '0; sb = '0;
      exp24 = {8'h00, a2} * {16'h0000, b2};
`endif
      @(posedge clk); #1;
      start2 = 1'b0; a2 = 16'($urandom); b2 = 8'($urandom);
      cyc = 0;
      while (!done2 && cyc < 30) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("rand_latency", cyc, 8);
      chk("rand_product", product2, exp24);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
